// File: rtl/mac_accumulator.sv
// mac_accumulator
//
// Accumulation stage that sits after the unsigned DataWidth x DataWidth
// multiplier. It sums a run of cfg_len products into one partial sum per
// convolution window. Each finished sum is held in a single-entry output
// register that has a valid/ready handshake. Accumulation saturates at
// 2^AccWidth-1, and a sticky flag reports that saturation happened.
//
// Parameters
//   DataWidth : multiplier operand width; in_prod is 2*DataWidth bits
//   AccWidth  : accumulator/output width, 2*DataWidth+1 .. 48
//   LenWidth  : width of the window-length configuration
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   cfg_len   in   products per window (0 behaves as 1), sampled on first beat
//   in_valid  in   product beat valid
//   in_ready  out  stage can accept a beat (!out_valid | out_ready)
//   in_prod   in   unsigned product
//   out_valid out  finished sum held in output register
//   out_ready in   downstream accepts the sum
//   out_sum   out  finished, saturated window sum
//   out_ovf   out  saturation occurred in the reported window

module mac_accumulator #(
    parameter int DataWidth = 8,
    parameter int AccWidth  = 24,
    parameter int LenWidth  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LenWidth-1:0]    cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*DataWidth-1:0] in_prod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AccWidth-1:0]    out_sum,
    output logic                   out_ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [AccWidth-1:0] acc, acc_next;
    logic [LenWidth-1:0] cnt, cnt_next;
    logic [LenWidth-1:0] len_q, len_next;
    logic                ovf, ovf_next;

    logic                accept;
    logic                done;
    logic [LenWidth-1:0] len_first;
    logic [AccWidth-1:0] beat_sum;
    logic                beat_ovf;
    logic [AccWidth-1:0] fin_sum;
    logic                fin_ovf;

    // Add one product to the running sum with one extra carry bit. The
    // result is {carry, value}. On carry, value is forced to all-ones.
    // Once acc is all-ones, any nonzero product carries again, so the
    // saturated value stays put for the rest of the window.
    function automatic logic [AccWidth:0] sat_add(
        input logic [AccWidth-1:0]    a,
        input logic [2*DataWidth-1:0] b
    );
        logic [AccWidth:0] s;
        s = {1'b0, a} + (AccWidth+1)'(b);
        if (s[AccWidth]) begin
            return {1'b1, {AccWidth{1'b1}}};
        end
        return s;
    endfunction

    // Handshake outputs and beat acceptance
    always_comb begin
        in_ready = ~out_valid | out_ready;
        accept   = in_valid & in_ready;
    end

    assign len_first = (cfg_len == '0) ? LenWidth'(1) : cfg_len;

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        len_next   = len_q;
        ovf_next   = ovf;
        done       = 1'b0;
        fin_sum    = '0;
        fin_ovf    = 1'b0;
        {beat_ovf, beat_sum} = sat_add(acc, in_prod);

        case (state)
            IDLE: begin
                if (accept) begin
                    len_next = len_first;
                    fin_sum  = AccWidth'(in_prod);
                    fin_ovf  = 1'b0;
                    if (len_first == LenWidth'(1)) begin
                        done = 1'b1;
                    end else begin
                        state_next = ACC;
                        acc_next   = AccWidth'(in_prod);
                        cnt_next   = LenWidth'(1);
                        ovf_next   = 1'b0;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    fin_sum = beat_sum;
                    fin_ovf = ovf | beat_ovf;
                    // cnt never exceeds len_q-1 here, so cnt+1 cannot wrap
                    if ((cnt + LenWidth'(1)) == len_q) begin
                        done = 1'b1;
                    end else begin
                        acc_next = beat_sum;
                        ovf_next = ovf | beat_ovf;
                        cnt_next = cnt + LenWidth'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (done) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end
    end

    // State and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            len_q <= len_next;
            ovf   <= ovf_next;
        end
    end

    // Output register: a completion reloads it. This covers a completion in
    // the same cycle as a transfer, which gives back-to-back sums with no
    // bubble. Otherwise a transfer empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_sum   <= fin_sum;
            out_ovf   <= fin_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator.
// Two instances run side by side on the same stimulus. One uses the default
// 24-bit accumulator and the other uses a 17-bit accumulator for the
// saturation cases. A negedge scoreboard predicts completions, pushes
// expected sums when a beat is accepted, and pops them on output transfers.
// Each test task also checks its own scenario-specific values inline.

module tb_mac_accumulator;

    localparam longint MAX_A = (64'd1 << 24) - 1;
    localparam longint MAX_B = (64'd1 << 17) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;

    logic        rdy_a, vld_a, ovf_a;
    logic [23:0] sum_a;
    logic        rdy_b, vld_b, ovf_b;
    logic [16:0] sum_b;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        longint sum;
        bit     ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // reference model state
    int     m_len, m_cnt;
    longint m_acc_a, m_acc_b;
    bit     m_ovf_a, m_ovf_b;
    bit     m_open   = 1'b0;
    bit     m_ovalid = 1'b0;
    bit     m_ready, m_xfer, m_done;
    exp_t   e;

    always #5 clk = ~clk;

    mac_accumulator #(.DataWidth(8), .AccWidth(24), .LenWidth(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (rdy_a),
        .in_prod   (in_prod),
        .out_valid (vld_a),
        .out_ready (out_ready),
        .out_sum   (sum_a),
        .out_ovf   (ovf_a)
    );

    mac_accumulator #(.DataWidth(8), .AccWidth(17), .LenWidth(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (rdy_b),
        .in_prod   (in_prod),
        .out_valid (vld_b),
        .out_ready (out_ready),
        .out_sum   (sum_b),
        .out_ovf   (ovf_b)
    );

    // Scoreboard and cycle model, evaluated half a cycle before each edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_open   = 1'b0;
            m_ovalid = 1'b0;
            q_a.delete();
            q_b.delete();
        end else begin
            m_ready = !m_ovalid || out_ready;
            m_xfer  = m_ovalid && out_ready;
            m_done  = 1'b0;

            n_total += 4;
            if (rdy_a !== m_ready) $display("FAIL in_ready_a: got %0b expected %0b", rdy_a, m_ready);
            else n_pass++;
            if (rdy_b !== m_ready) $display("FAIL in_ready_b: got %0b expected %0b", rdy_b, m_ready);
            else n_pass++;
            if (vld_a !== m_ovalid) $display("FAIL out_valid_a: got %0b expected %0b", vld_a, m_ovalid);
            else n_pass++;
            if (vld_b !== m_ovalid) $display("FAIL out_valid_b: got %0b expected %0b", vld_b, m_ovalid);
            else n_pass++;

            if (m_xfer) begin
                n_total += 2;
                if (q_a.size() == 0) begin
                    $display("FAIL sb_a: transfer of %0d with no expected entry", sum_a);
                end else begin
                    e = q_a.pop_front();
                    if (sum_a !== e.sum || ovf_a !== e.ovf)
                        $display("FAIL sb_a: got sum %0d ovf %0b expected sum %0d ovf %0b",
                                 sum_a, ovf_a, e.sum, e.ovf);
                    else n_pass++;
                end
                if (q_b.size() == 0) begin
                    $display("FAIL sb_b: transfer of %0d with no expected entry", sum_b);
                end else begin
                    e = q_b.pop_front();
                    if (sum_b !== e.sum || ovf_b !== e.ovf)
                        $display("FAIL sb_b: got sum %0d ovf %0b expected sum %0d ovf %0b",
                                 sum_b, ovf_b, e.sum, e.ovf);
                    else n_pass++;
                end
            end

            if (in_valid && m_ready) begin
                if (!m_open) begin
                    m_len   = (cfg_len == 0) ? 1 : int'(cfg_len);
                    m_cnt   = 1;
                    m_acc_a = in_prod;
                    m_acc_b = in_prod;
                    m_ovf_a = 1'b0;
                    m_ovf_b = 1'b0;
                end else begin
                    m_cnt++;
                    m_acc_a += in_prod;
                    m_acc_b += in_prod;
                    if (m_acc_a > MAX_A) begin m_acc_a = MAX_A; m_ovf_a = 1'b1; end
                    if (m_acc_b > MAX_B) begin m_acc_b = MAX_B; m_ovf_b = 1'b1; end
                end
                if (m_cnt == m_len) begin
                    q_a.push_back('{sum: m_acc_a, ovf: m_ovf_a});
                    q_b.push_back('{sum: m_acc_b, ovf: m_ovf_b});
                    m_done = 1'b1;
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end

            if (m_done) m_ovalid = 1'b1;
            else if (m_xfer) m_ovalid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_len = 8'd0; in_valid = 1'b0; in_prod = 16'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_total += 4;
        if (vld_a !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", vld_a); else n_pass++;
        if (sum_a !== 24'd0) $display("FAIL reset_sum: got %0d expected 0", sum_a); else n_pass++;
        if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %0b expected 0", ovf_a); else n_pass++;
        if (rdy_a !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", rdy_a); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (rdy_a !== 1'b1) $display("FAIL post_reset_ready: got %0b expected 1", rdy_a); else n_pass++;
    endtask

    task automatic test_basic();
        int prods[3] = '{10, 20, 30};
        out_ready = 1'b1; cfg_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_prod = 16'(prods[i]);
            tick();
            n_total++;
            if (vld_a !== (i == 2)) $display("FAIL basic_valid_%0d: got %0b expected %0b", i, vld_a, (i == 2));
            else n_pass++;
        end
        n_total += 2;
        if (sum_a !== 24'd60) $display("FAIL basic_sum: got %0d expected 60", sum_a); else n_pass++;
        if (ovf_a !== 1'b0) $display("FAIL basic_ovf: got %0b expected 0", ovf_a); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++;
        if (vld_a !== 1'b0) $display("FAIL basic_one_cycle: got %0b expected 0", vld_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int prods[4] = '{5, 7, 100, 1};
        out_ready = 1'b1; cfg_len = 8'd2;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_prod = 16'(prods[i]);
            n_total++;
            if (rdy_a !== 1'b1) $display("FAIL b2b_ready_%0d: got %0b expected 1", i, rdy_a); else n_pass++;
            tick();
            if (i == 1) begin
                n_total++;
                if (vld_a !== 1'b1 || sum_a !== 24'd12)
                    $display("FAIL b2b_sum0: got valid %0b sum %0d expected valid 1 sum 12", vld_a, sum_a);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++;
                if (vld_a !== 1'b1 || sum_a !== 24'd101)
                    $display("FAIL b2b_sum1: got valid %0b sum %0d expected valid 1 sum 101", vld_a, sum_a);
                else n_pass++;
            end
        end
        idle(1);
    endtask

    task automatic test_len_edges();
        out_ready = 1'b1;
        cfg_len = 8'd0; in_valid = 1'b1; in_prod = 16'd65025;
        tick();
        n_total++;
        if (vld_a !== 1'b1 || sum_a !== 24'd65025)
            $display("FAIL len0_sum: got valid %0b sum %0d expected valid 1 sum 65025", vld_a, sum_a);
        else n_pass++;
        cfg_len = 8'd1;
        for (int i = 1; i <= 3; i++) begin
            in_prod = 16'(i * 11);
            tick();
            n_total++;
            if (vld_a !== 1'b1 || sum_a !== 24'(i * 11))
                $display("FAIL len1_sum_%0d: got valid %0b sum %0d expected valid 1 sum %0d", i, vld_a, sum_a, i * 11);
            else n_pass++;
        end
        cfg_len = 8'd255; in_prod = 16'd1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i == 1) cfg_len = 8'd3;
            if (i == 254) begin
                n_total++;
                if (vld_a !== 1'b0) $display("FAIL len255_early: got valid %0b expected 0", vld_a); else n_pass++;
            end
        end
        n_total++;
        if (vld_a !== 1'b1 || sum_a !== 24'd255)
            $display("FAIL len255_sum: got valid %0b sum %0d expected valid 1 sum 255", vld_a, sum_a);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; cfg_len = 8'd1; in_valid = 1'b1; in_prod = 16'd3;
        tick();
        in_prod = 16'd4;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (vld_a !== 1'b1 || sum_a !== 24'd3 || rdy_a !== 1'b0)
                $display("FAIL bp_hold_%0d: got valid %0b sum %0d ready %0b expected valid 1 sum 3 ready 0",
                         i, vld_a, sum_a, rdy_a);
            else n_pass++;
            if (i < 4) tick();
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (rdy_a !== 1'b1) $display("FAIL bp_release_ready: got %0b expected 1", rdy_a); else n_pass++;
        tick();
        n_total++;
        if (vld_a !== 1'b1 || sum_a !== 24'd4)
            $display("FAIL bp_next: got valid %0b sum %0d expected valid 1 sum 4", vld_a, sum_a);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; cfg_len = 8'd4; in_valid = 1'b1; in_prod = 16'd65025;
        repeat (4) tick();
        n_total += 2;
        if (sum_b !== 17'd131071 || ovf_b !== 1'b1)
            $display("FAIL sat_b: got sum %0d ovf %0b expected sum 131071 ovf 1", sum_b, ovf_b);
        else n_pass++;
        if (sum_a !== 24'd260100 || ovf_a !== 1'b0)
            $display("FAIL sat_a: got sum %0d ovf %0b expected sum 260100 ovf 0", sum_a, ovf_a);
        else n_pass++;
        cfg_len = 8'd2; in_prod = 16'd1;
        repeat (2) tick();
        n_total++;
        if (sum_b !== 17'd2 || ovf_b !== 1'b0)
            $display("FAIL sat_after: got sum %0d ovf %0b expected sum 2 ovf 0", sum_b, ovf_b);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_reset_mid();
        // A held output is cleared asynchronously
        out_ready = 1'b0; cfg_len = 8'd1; in_valid = 1'b1; in_prod = 16'd200;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (vld_a !== 1'b0 || sum_a !== 24'd0 || ovf_a !== 1'b0 || rdy_a !== 1'b1)
            $display("FAIL rst_held: got valid %0b sum %0d ovf %0b ready %0b expected 0 0 0 1",
                     vld_a, sum_a, ovf_a, rdy_a);
        else n_pass++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        // Partial window 9, 9 then reset
        cfg_len = 8'd4; in_valid = 1'b1; in_prod = 16'd9;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++;
        if (vld_a !== 1'b0 || sum_a !== 24'd0 || ovf_a !== 1'b0)
            $display("FAIL rst_mid: got valid %0b sum %0d ovf %0b expected 0 0 0", vld_a, sum_a, ovf_a);
        else n_pass++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cfg_len = 8'd4; in_valid = 1'b1; in_prod = 16'd1;
        repeat (4) tick();
        n_total++;
        if (vld_a !== 1'b1 || sum_a !== 24'd4)
            $display("FAIL rst_residue: got valid %0b sum %0d expected valid 1 sum 4", vld_a, sum_a);
        else n_pass++;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_len_edges();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        idle(2);
        n_total++;
        if (q_a.size() != 0 || q_b.size() != 0)
            $display("FAIL sb_drain: got %0d/%0d entries left expected 0/0", q_a.size(), q_b.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
